// File: rtl/stream_mux_pkg.sv
// Shared constants, lock-state type and the round-robin pick helper for stream_mux_rr.
package stream_mux_pkg;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_W     = 8;
  // Upper bound on channel count; the helper works on vectors of this width.
  localparam int MAX_CH    = 64;
  localparam int MAX_SEL_W = $clog2(MAX_CH);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // One-hot grant to the first set bit of valid, scanning cyclically from ptr over n_ch bits.
  function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0]    valid,
                                                input logic [MAX_SEL_W-1:0] ptr,
                                                input int unsigned          n_ch);
    logic [MAX_CH-1:0] grant;
    logic              found;
    int unsigned       idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= n_ch) idx = idx - n_ch;
      if (k < n_ch && !found && valid[idx[MAX_SEL_W-1:0]]) begin
        grant[idx[MAX_SEL_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = DEF_N_CH,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  grant
);

  logic [MAX_CH-1:0]    req_ext;
  logic [MAX_CH-1:0]    grant_ext;
  logic [MAX_SEL_W-1:0] ptr_ext;
  logic                 unused_hi;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    req_ext            = '0;
    req_ext[N_CH-1:0]  = req;
    ptr_ext            = '0;
    ptr_ext[SEL_W-1:0] = ptr;
    grant_ext          = rr_pick(req_ext, ptr_ext, N_CH);
  end

  assign grant     = grant_ext[N_CH-1:0];
  // Bits above N_CH are always zero; folded here so they are visibly consumed.
  assign unused_hi = ^grant_ext[MAX_CH-1:N_CH];

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with round-robin arbitration and a registered output stage.
// Define STREAM_MUX_PKT_LOCK_EN to hold arbitration on one channel until its in_last beat.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = DEF_N_CH,
  parameter  int W     = DEF_W,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH-1:0]   in_last,
  output logic [N_CH-1:0]   in_ready,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic [SEL_W-1:0]  out_sel,
  input  logic              out_ready
);

  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  grant;
  logic             load_ok;
  logic             xfer;
  logic [SEL_W-1:0] g_idx;
  logic [SEL_W-1:0] ptr_next;
  logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;
  logic [W-1:0]     out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q,  out_last_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;

`ifdef STREAM_MUX_PKT_LOCK_EN
  lock_state_t lock_q, lock_d;

  // While locked the owner is the channel of the beat currently held, i.e. out_sel_q.
  assign req = (lock_q == LOCKED) ? (in_valid & (N_CH'(1) << out_sel_q)) : in_valid;
`else
  assign req = in_valid;
`endif

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req   (req),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  assign load_ok  = !out_valid_q || out_ready;
  assign in_ready = grant & {N_CH{load_ok && !rst}};
  assign xfer     = |in_ready;

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) g_idx = SEL_W'(i);
    end
  end

  assign ptr_next = (g_idx == SEL_W'(N_CH - 1)) ? '0 : g_idx + 1'b1;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
    lock_d      = lock_q;
`endif
    if (xfer) begin
      out_data_d  = in_data[g_idx*W +: W];
      out_last_d  = in_last[g_idx];
      out_sel_d   = g_idx;
      out_valid_d = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
      if (in_last[g_idx]) begin
        lock_d   = UNLOCKED;
        rr_ptr_d = ptr_next;
      end else begin
        lock_d   = LOCKED;
      end
`else
      rr_ptr_d    = ptr_next;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) lock_q <= UNLOCKED;
    else     lock_q <= lock_d;
  end
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed self-checking bench for stream_mux_rr (N_CH=4, W=8); honours STREAM_MUX_PKT_LOCK_EN.
module tb_stream_mux_rr;

  localparam int N_CH = 4;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_valid;
  logic [N_CH-1:0]   in_last;
  logic [N_CH-1:0]   in_ready;
  logic [W-1:0]      out_data;
  logic              out_valid;
  logic              out_last;
  logic [1:0]        out_sel;
  logic              out_ready;

  int passed = 0;
  int total  = 0;

  stream_mux_rr #(.N_CH(N_CH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_sel  [4];
    int exp_last [4];
    int beats1;

    // Reset with ch0 already offering A5: nothing may move while rst is high.
    rst       = 1'b1;
    in_data   = {8'h00, 8'h00, 8'h00, 8'hA5};
    in_valid  = 4'b0001;
    in_last   = 4'b1111;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data",  32'(out_data),  32'h0);
    check("rst_out_last",  32'(out_last),  32'h0);
    check("rst_out_sel",   32'(out_sel),   32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h0);

    rst = 1'b0;
    #1;
    check("basic_in_ready", 32'(in_ready), 32'h1);
    tick();
    check("basic_out_valid", 32'(out_valid), 32'h1);
    check("basic_out_data",  32'(out_data),  32'hA5);
    check("basic_out_sel",   32'(out_sel),   32'h0);

    // Reset while a beat is held and stalled: the beat is dropped.
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    check("held_beat_dropped", 32'(out_valid), 32'h0);

    // Fairness: all channels valid, single-beat packets, no stall.
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("fair_sel_%0d", k),  32'(out_sel),  32'(k % 4));
      check($sformatf("fair_data_%0d", k), 32'(out_data), 32'h10 + 32'(k % 4));
    end

    // Backpressure: ch3 beat held; nothing accepted, pointer frozen at ch0.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall_in_ready_%0d", k), 32'(in_ready), 32'h0);
      tick();
      check($sformatf("stall_data_%0d", k),  32'(out_data),  32'h13);
      check($sformatf("stall_valid_%0d", k), 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", 32'(in_ready), 32'h1);
    tick();
    check("unstall_sel",  32'(out_sel),  32'h0);
    check("unstall_data", 32'(out_data), 32'h10);

    // Wrap and sparse requests: ch2 transfer leaves rr_ptr=3.
    in_valid = 4'b0100;
    tick();
    check("sparse_ch2_sel", 32'(out_sel), 32'h2);
    in_valid = 4'b0101;
    #1;
    check("wrap_in_ready", 32'(in_ready), 32'h1);
    tick();
    check("wrap_sel",  32'(out_sel),  32'h0);
    check("wrap_data", 32'(out_data), 32'h10);
    #1;
    check("sparse_in_ready", 32'(in_ready), 32'h4);
    tick();
    check("sparse_sel",  32'(out_sel),  32'h2);
    check("sparse_data", 32'(out_data), 32'h12);

    // Packet: ch1 sends last=0,0,1 with ch2 continuously valid (ch2 packets are single-beat).
`ifdef STREAM_MUX_PKT_LOCK_EN
    exp_sel  = '{1, 1, 1, 2};
    exp_last = '{0, 0, 1, 1};
`else
    exp_sel  = '{1, 2, 1, 2};
    exp_last = '{0, 1, 0, 1};
`endif
    beats1 = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = {1'b0, 1'b1, (beats1 < 3), 1'b0};
      in_last  = {1'b1, 1'b1, (beats1 == 2), 1'b1};
      tick();
      check($sformatf("pkt_sel_%0d", k),  32'(out_sel),  32'(exp_sel[k]));
      check($sformatf("pkt_last_%0d", k), 32'(out_last), 32'(exp_last[k]));
      if (exp_sel[k] == 1) beats1++;
    end

    // Mid-packet reset: two non-last beats of a ch3 packet, then reset.
    in_valid = 4'b1000;
    in_last  = 4'b0000;
    tick();
    check("mid_beat1_sel", 32'(out_sel), 32'h3);
    tick();
    check("mid_beat2_sel", 32'(out_sel), 32'h3);
    in_valid = 4'b1010;
    rst      = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    check("mid_rst_out_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'h2);
    tick();
    check("post_rst_sel",   32'(out_sel),   32'h1);
    check("post_rst_data",  32'(out_data),  32'h11);
    check("post_rst_valid", 32'(out_valid), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit valid/ready stream multiplexer with round-robin arbitration and a registered output stage. It generalises the fixed 4:1, 4-bit combinational mux to any channel count and width, and adds flow control, fair arbitration and optional packet locking. It sits between several producer streams and a single consumer stream.

## Interface
- `N_CH`, 4: number of input channels, ≥ 2.
- `W`, 8: data width per channel, ≥ 1.
- `SEL_W`, `$clog2(N_CH)`: local parameter, width of the channel index.

Ports (clock and reset first):
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_data` in N_CH*W: channel i occupies bits [i*W +: W].
- `in_valid` in N_CH: per-channel valid.
- `in_last` in N_CH: per-channel end-of-packet marker.
- `in_ready` out N_CH: per-channel ready. Combinational.
- `out_data` out W: registered data.
- `out_valid` out 1: registered valid.
- `out_last` out 1: registered last.
- `out_sel` out SEL_W: registered index of the channel that supplied the current output beat.
- `out_ready` in 1: consumer ready.

## Operation
- Transfer on any port: valid && ready at a rising edge of `clk`.
- Output register can accept a beat (`load_ok`) when `!out_valid || out_ready`.
- Arbiter grant:
  - One-hot, combinational.
  - Grants the first channel with `in_valid` set, scanning cyclically from `rr_ptr`.
  - No valid inputs: no grant.
- `in_ready[i] = grant[i] && load_ok && !rst`. At most one bit of `in_ready` is set.
- On an input transfer from channel g:
  - `out_data`, `out_last` and `out_sel` load from channel g.
  - `out_valid` is set to 1.
- `out_valid` clears when `out_ready` is high and no new beat loads in the same cycle.
- A simultaneous drain and load is allowed, giving 1 beat per cycle of throughput.
- `rr_ptr` update after a transfer from channel g: `rr_ptr` becomes (g+1) mod N_CH. It wraps from N_CH-1 to 0. Under packet locking, this happens only when the packet ends (see Configuration).
- `rr_ptr` does not change when there is no transfer.
- A producer that raises valid without seeing ready must hold its data and last stable. The block neither checks nor relies on this.
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_last` = 0, `out_sel` = 0.
  - `rr_ptr` = 0, lock state = unlocked.
  - `in_ready` = all 0 while `rst` is high.
- Reset in the middle of a packet or with a beat held in the output register: all state is discarded and the held beat is dropped. The first grant after reset starts from channel 0.

## Timing
- Latency from input transfer to `out_valid`/`out_data` is exactly 1 cycle.
- The `out_ready` → `in_ready` path is combinational (no skid buffer). `in_valid` → `in_ready` is also combinational through the arbiter.
- Sustained throughput is 1 beat per cycle while `out_ready` stays high.
- With all channels continuously valid and the output never stalled, grants rotate 0,1,…,N_CH-1,0,… one beat each. Under locking, the rotation is one packet each.
- Stall: while `out_valid` && !`out_ready`:
  - all `in_ready` bits are 0;
  - `out_*` stay stable;
  - `rr_ptr` is frozen.

## Configuration
- `STREAM_MUX_PKT_LOCK_EN` defined:
  - After a transfer with `in_last` = 0, the arbiter locks to that channel.
  - While locked, the grant goes only to the locked channel, even if other channels are valid.
  - The lock releases, and `rr_ptr` advances, on the transfer with `in_last` = 1.
  - A single-beat packet (last = 1 on the first beat) never locks.
- Not defined:
  - Arbitration is per beat.
  - `in_last` is passed to `out_last` unchanged but has no effect on arbitration.

## Structure
- Package `stream_mux_pkg` holds:
  - default width constants;
  - a helper function `rr_pick(valid, ptr)` that returns a one-hot grant;
  - the `lock_state_t` typedef (enum UNLOCKED/LOCKED).
- One sub-module, `rr_arbiter`: parameter N_CH, inputs `req`, `ptr`, output one-hot `grant`. It is combinational. It is tested alone and then instantiated by the top.
- The top holds the output register, `rr_ptr` and the lock FSM.

## Test plan
- Reset and basic transfer: N_CH=4, W=8.
  - Stimulus: `rst` for 2 cycles, then `in_valid`=0001, ch0 data=8'hA5, `out_ready`=1.
  - Required: during reset all outputs are 0. Next cycle `out_valid`=1, `out_data`=A5, `out_sel`=0.
- Fairness: all 4 channels continuously valid with data 8'h10+i, `out_ready`=1, 8 cycles.
  - Required: `out_sel` sequence 0,1,2,3,0,1,2,3; `out_data` sequence 10,11,12,13,10,11,12,13.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 3 cycles with `out_valid`=1.
  - Required: `in_ready`=0000 and `out_data` is unchanged throughout. On `out_ready`=1, the next channel in rotation transfers that same cycle.
- Wrap and sparse requests:
  - Stimulus: `rr_ptr`=3 (after a ch2 transfer), `in_valid`=0101.
  - Required: grant goes to ch0, then ch2.
- Packet lock (macro defined): ch1 sends 3 beats with last=0,0,1 while ch2 is continuously valid.
  - Required: `out_sel`=1,1,1, then 2.
  - Without the macro: `out_sel`=1,2,1,2.
- Mid-packet reset (macro defined):
  - Stimulus: assert `rst` after beat 2 of a 4-beat ch3 packet.
  - Required: `out_valid` = 0 after reset, the lock is cleared, and the first grant goes to the lowest valid channel starting from 0.
